// File: rtl/rr_stream_mux.sv
// rr_stream_mux: packet-aware round-robin multiplexer for valid/ready streams.
// Merges NUM_REQ input streams onto one output stream. It arbitrates only at
// packet boundaries and keeps the grant until the granted source's last beat
// is accepted, so beats of different packets never interleave.
//
// Ports:
//   clk, rst_n           clock (posedge) and asynchronous active-low reset
//   in_valid/in_last     per-source beat valid / last beat of packet
//   in_data              source i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready             per-source ready, one-hot or zero
//   out_valid/out_data/out_last  merged beat
//   out_id               index of the source owning the current packet
//   out_ready            downstream ready
module rr_stream_mux #(
  parameter int unsigned WINNER_WIDTH = 2,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [WINNER_WIDTH-1:0]       out_id,
  input  logic                          out_ready
);

  localparam logic [WINNER_WIDTH-1:0] LAST_IDX = WINNER_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state;
  logic [WINNER_WIDTH-1:0] grant_q;
  logic [WINNER_WIDTH-1:0] hi_pri_q;
  logic [WINNER_WIDTH-1:0] winner;
  logic [WINNER_WIDTH-1:0] hi_win;
  logic [WINNER_WIDTH-1:0] lo_win;
  logic                    hi_hit;

  // Round-robin pick: lowest requester at or above hi_pri_q, else lowest overall.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    hi_win = '0;
    lo_win = '0;
    hi_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_win = WINNER_WIDTH'(i);
        if (32'(i) >= 32'(hi_pri_q)) begin
          hi_win = WINNER_WIDTH'(i);
          hi_hit = 1'b1;
        end
      end
    end
    winner = hi_hit ? hi_win : lo_win;
  end

  // Zero-latency passthrough of the granted source while a packet is locked.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state == LOCK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == WINNER_WIDTH'(i)) begin
          out_valid   = in_valid[i];
          out_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_last    = in_last[i];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  assign out_id = grant_q;

  // Arbitration state: grant taken in IDLE, released on an accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      hi_pri_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            grant_q <= winner;
            state   <= LOCK;
          end
        end
        LOCK: begin
          if (out_valid && out_ready && out_last) begin
            state    <= IDLE;
            hi_pri_q <= (grant_q == LAST_IDX) ? '0 : grant_q + WINNER_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-source instance and a 3-source instance.
module tb_rr_stream_mux;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;

  logic [3:0]    in_valid, in_last, in_ready;
  logic [4*DW-1:0] in_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;

  logic [2:0]    v3, l3, r3;
  logic [3*DW-1:0] d3;
  logic          ov3, ol3, ordy3;
  logic [DW-1:0] od3;
  logic [1:0]    oid3;

  int vectors    = 0;
  int miscompares = 0;
  int acc        = 0;
  int a0;

  rr_stream_mux #(.WINNER_WIDTH(2), .NUM_REQ(4), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.WINNER_WIDTH(2), .NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
    .in_last(l3), .in_ready(r3), .out_valid(ov3),
    .out_data(od3), .out_last(ol3), .out_id(oid3),
    .out_ready(ordy3)
  );

  always #5 clk = ~clk;

  // Accepted beats on the 4-source output.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) acc <= acc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  function automatic logic [DW-1:0] beat_val(input int src, input int beat);
    return DW'(32'hA000 + src * 256 + beat);
  endfunction

  task automatic set_beat(input int src, input int beat);
    in_data[src*DW +: DW] = beat_val(src, beat);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b0;

    // Reset values
    repeat (2) tick();
    sample();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst3_out_valid", 64'(ov3), 64'(0));

    // All four sources, 1-beat packets: 0,1,2,3,0 with a bubble each
    tick();
    rst_n = 1'b1;
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) set_beat(s, 0);
    for (int k = 0; k < 5; k++) begin
      sample();
      check("t1_bubble", 64'(out_valid), 64'(0));
      tick();
      sample();
      check("t1_out_id", 64'(out_id), 64'(k % 4));
      check("t1_out_valid", 64'(out_valid), 64'(1));
      check("t1_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
      check("t1_out_data", 64'(out_data), 64'(beat_val(k % 4, 0)));
      tick();
    end
    in_valid = '0; in_last = '0;

    // Src2 4-beat packet; src0 requests from beat 2 but must wait
    a0 = acc;
    in_valid = 4'b0100;
    set_beat(2, 0);
    sample();
    check("t2_bubble", 64'(out_valid), 64'(0));
    tick();
    for (int b = 0; b < 4; b++) begin
      set_beat(2, b);
      in_last = (b == 3) ? 4'b0100 : 4'b0000;
      if (b >= 1) begin
        in_valid = 4'b0101;
        set_beat(0, 0);
      end
      sample();
      check("t2_out_id", 64'(out_id), 64'(2));
      check("t2_out_data", 64'(out_data), 64'(beat_val(2, b)));
      check("t2_in_ready", 64'(in_ready), 64'(4'b0100));
      check("t2_out_last", 64'(out_last), 64'(b == 3));
      tick();
    end
    check("t2_beats", 64'(acc - a0), 64'(4));
    in_valid = 4'b0001; in_last = 4'b0001;
    sample();
    check("t2_bubble2", 64'(out_valid), 64'(0));
    tick();
    sample();
    check("t2_src0_id", 64'(out_id), 64'(0));
    check("t2_src0_data", 64'(out_data), 64'(beat_val(0, 0)));
    tick();
    in_valid = '0; in_last = '0;

    // Src1 3-beat packet with a 3-cycle downstream stall on beat 1
    a0 = acc;
    in_valid = 4'b0010;
    set_beat(1, 0);
    tick();
    sample();
    check("t3_out_id", 64'(out_id), 64'(1));
    check("t3_beat0", 64'(out_data), 64'(beat_val(1, 0)));
    tick();
    set_beat(1, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t3_stall_valid", 64'(out_valid), 64'(1));
      check("t3_stall_data", 64'(out_data), 64'(beat_val(1, 1)));
      check("t3_stall_ready", 64'(in_ready), 64'(0));
      check("t3_stall_id", 64'(out_id), 64'(1));
      check("t3_stall_last", 64'(out_last), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    sample();
    check("t3_resume_ready", 64'(in_ready), 64'(4'b0010));
    check("t3_resume_data", 64'(out_data), 64'(beat_val(1, 1)));
    tick();
    set_beat(1, 2);
    in_last = 4'b0010;
    sample();
    check("t3_last", 64'(out_last), 64'(1));
    check("t3_beat2", 64'(out_data), 64'(beat_val(1, 2)));
    tick();
    check("t3_beats", 64'(acc - a0), 64'(3));
    in_valid = '0; in_last = '0;

    // Reset during beat 2 of a src3 packet; afterwards hi_pri restarts at 0
    in_valid = 4'b1000;
    set_beat(3, 0);
    tick();
    sample();
    check("t5_out_id", 64'(out_id), 64'(3));
    tick();
    set_beat(3, 1);
    sample();
    check("t5_beat1", 64'(out_data), 64'(beat_val(3, 1)));
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'(0));
    check("t5_rst_ready", 64'(in_ready), 64'(0));
    check("t5_rst_id", 64'(out_id), 64'(0));
    tick();
    in_valid = 4'b1010; in_last = 4'b1010;
    set_beat(1, 0);
    rst_n = 1'b1;
    sample();
    check("t5_bubble", 64'(out_valid), 64'(0));
    tick();
    sample();
    check("t5_first_grant", 64'(out_id), 64'(1));
    check("t5_first_data", 64'(out_data), 64'(beat_val(1, 0)));
    tick();
    in_valid = '0; in_last = '0;

    // Only src3 requesting, back-to-back 1-beat packets
    in_valid = 4'b1000; in_last = 4'b1000;
    set_beat(3, 0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t6_bubble", 64'(out_valid), 64'(0));
      check("t6_idle_id", 64'(out_id), 64'((k == 0) ? 1 : 3));
      tick();
      sample();
      check("t6_out_id", 64'(out_id), 64'(3));
      check("t6_in_ready", 64'(in_ready), 64'(4'b1000));
      tick();
    end
    in_valid = '0; in_last = '0;

    // NUM_REQ=3: grants 0,1,2,0, never index 3
    v3 = 3'b111; l3 = 3'b111; ordy3 = 1'b1;
    for (int s = 0; s < 3; s++) d3[s*DW +: DW] = beat_val(s, 0);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("t4_bubble", 64'(ov3), 64'(0));
      tick();
      sample();
      check("t4_out_id", 64'(oid3), 64'(k % 3));
      check("t4_in_ready", 64'(r3), 64'(3'b001 << (k % 3)));
      check("t4_out_data", 64'(od3), 64'(beat_val(k % 3, 0)));
      tick();
    end
    v3 = '0; l3 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
